// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: defaults, grant encoding, width helper.
package dmem_port_arbiter_pkg;

  localparam logic [31:0] KB_BUF_BASE_DEFAULT = 32'h0000_0100;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_KB  = 1'b1;

  typedef enum logic {
    StGrantCpu,
    StGrantKbSteal
  } arb_state_e;

  // Bits needed to index n entries; never less than 1.
  function automatic int unsigned log2w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/kb_fifo.sv
// Small synchronous FIFO for keyboard scan codes; DEPTH must be a power of two and at least 2.
module kb_fifo
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = log2w(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data RAM between the CPU load/store port and a keyboard scan-code ring buffer,
// using idle CPU slots or a one-cycle CPU stall when the keyboard has waited too long.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned KB_FIFO_DEPTH = 4,
  parameter logic [31:0] KB_BUF_BASE   = KB_BUF_BASE_DEFAULT,
  parameter int unsigned KB_BUF_WORDS  = 16,
  parameter int unsigned MAX_WAIT      = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_cs,
  input  logic                            cpu_r,
  input  logic                            cpu_w,
  input  logic [31:0]                     cpu_addr,
  input  logic [31:0]                     cpu_wdata,
  output logic [31:0]                     cpu_rdata,
  output logic                            cpu_stall,
  input  logic                            kb_valid,
  input  logic [7:0]                      kb_code,
  output logic                            kb_ready,
  output logic                            mem_cs,
  output logic                            mem_r,
  output logic                            mem_w,
  output logic [31:0]                     mem_addr,
  output logic [31:0]                     mem_wdata,
  input  logic [31:0]                     mem_rdata,
  output logic [log2w(KB_BUF_WORDS)-1:0]  kb_wr_ptr,
  output logic                            kb_overflow
);

  localparam int unsigned PW = log2w(KB_BUF_WORDS);
  localparam int unsigned WW = log2w(MAX_WAIT + 1);

  arb_state_e    state_q;
  logic          steal_q, steal_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [PW-1:0] ptr_q;
  logic          ovf_q;
  logic          gnt;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [31:0]   kb_addr;

  kb_fifo #(
    .DEPTH (KB_FIFO_DEPTH),
    .WIDTH (8)
  ) u_kb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (kb_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign steal_q = (state_q == StGrantKbSteal);

  // While rst is high the block is transparent: CPU grant, no stall, FIFO shown as ready.
  always_comb begin
    gnt = GNT_CPU;
    if (!rst) begin
      if (steal_q) begin
        gnt = GNT_KB;
      end else if (!fifo_empty && !cpu_cs) begin
        gnt = GNT_KB;
      end
    end
  end

  assign kb_ready  = rst || !fifo_full;
  assign push      = kb_valid && !fifo_full && !rst;
  assign pop       = (gnt == GNT_KB);
  assign cpu_stall = steal_q && !rst;
  assign cpu_rdata = mem_rdata;
  assign kb_addr   = KB_BUF_BASE + {{(30 - PW){1'b0}}, ptr_q, 2'b00};

  always_comb begin
    mem_cs    = cpu_cs;
    mem_r     = cpu_r;
    mem_w     = cpu_w;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (gnt == GNT_KB) begin
      mem_cs    = 1'b1;
      mem_r     = 1'b0;
      mem_w     = 1'b1;
      mem_addr  = kb_addr;
      mem_wdata = {24'h0, fifo_head};
    end
  end

  // A steal is only requested on a CPU-granted cycle with data waiting, so the
  // stolen slot always has an entry to drain and never follows another steal.
  always_comb begin
    wait_d = '0;
    if (!fifo_empty && gnt == GNT_CPU) begin
      wait_d = wait_q + WW'(1);
    end
    steal_d = 1'b0;
    if (!steal_q && !fifo_empty && gnt == GNT_CPU) begin
      steal_d = (wait_d == WW'(MAX_WAIT)) || (fifo_full && kb_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StGrantCpu;
      wait_q  <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StGrantCpu:     state_q <= steal_d ? StGrantKbSteal : StGrantCpu;
        StGrantKbSteal: state_q <= StGrantCpu;
      endcase
      wait_q <= wait_d;
      if (pop) begin
        ptr_q <= ptr_q + PW'(1);
      end
      if (kb_valid && fifo_full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign kb_wr_ptr   = ptr_q;
  assign kb_overflow = ovf_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench: directed stimulus queues expected RAM accesses, a monitor checks each one.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cs, cpu_r, cpu_w;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        kb_valid;
  logic [7:0]  kb_code;
  logic        kb_ready;
  logic        mem_cs, mem_r, mem_w;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  kb_wr_ptr;
  logic        kb_overflow;

  dmem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_cs      (cpu_cs),
    .cpu_r       (cpu_r),
    .cpu_w       (cpu_w),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .kb_valid    (kb_valid),
    .kb_code     (kb_code),
    .kb_ready    (kb_ready),
    .mem_cs      (mem_cs),
    .mem_r       (mem_r),
    .mem_w       (mem_w),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .kb_wr_ptr   (kb_wr_ptr),
    .kb_overflow (kb_overflow)
  );

  always #5 clk = ~clk;

  // Fake RAM read data, distinct per address.
  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

  typedef struct packed {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
  } txn_t;

  txn_t exp_q[$];
  txn_t mon_e, mon_a;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_cs === 1'b1) begin
      mon_a = '{r: mem_r, w: mem_w, addr: mem_addr, wdata: mem_wdata, stall: cpu_stall};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_access: got r=%b w=%b addr=%h wdata=%h stall=%b expected none",
                 mem_r, mem_w, mem_addr, mem_wdata, cpu_stall);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL mem_txn: got r=%b w=%b addr=%h wdata=%h stall=%b expected r=%b w=%b addr=%h wdata=%h stall=%b",
                   mon_a.r, mon_a.w, mon_a.addr, mon_a.wdata, mon_a.stall,
                   mon_e.r, mon_e.w, mon_e.addr, mon_e.wdata, mon_e.stall);
        end
      end
    end
  end

  task automatic set_in(input logic cs, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic kv, input logic [7:0] kc);
    cpu_cs = cs; cpu_r = r; cpu_w = w; cpu_addr = a; cpu_wdata = wd;
    kb_valid = kv; kb_code = kc;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic exp_cpu_rd(input logic [31:0] a);
    exp_q.push_back('{r: 1'b1, w: 1'b0, addr: a, wdata: 32'h0, stall: 1'b0});
  endtask

  task automatic exp_kb(input logic [31:0] a, input logic [7:0] c, input logic st);
    exp_q.push_back('{r: 1'b0, w: 1'b1, addr: a, wdata: {24'h0, c}, stall: st});
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    to_pos();
    to_pos();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  c;
    rst = 1'b1;
    idle();
    // Reset outputs
    to_neg();
    chk("rst_kb_ready", kb_ready, 1);
    chk("rst_cpu_stall", cpu_stall, 0);
    to_pos();
    to_pos();
    rst = 1'b0;

    // Pass-through load
    set_in(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 8'h00);
    exp_cpu_rd(32'h10);
    to_neg();
    chk("pt_stall", cpu_stall, 0);
    chk("pt_kb_ready", kb_ready, 1);
    chk("pt_ptr", kb_wr_ptr, 0);
    chk("pt_ovf", kb_overflow, 0);
    chk("pt_rdata", cpu_rdata, 32'hA5A5_0010);
    to_pos();

    // Idle-slot write
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 8'h1C);
    to_neg();
    to_pos();
    idle();
    exp_kb(32'h100, 8'h1C, 1'b0);
    to_neg();
    chk("idle_stall", cpu_stall, 0);
    chk("idle_ptr_during", kb_wr_ptr, 0);
    to_pos();
    to_neg();
    chk("idle_ptr_after", kb_wr_ptr, 1);
    to_pos();

    // Forced steal under saturated CPU traffic
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 8'h32);
    exp_cpu_rd(32'h20);
    to_neg();
    to_pos();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 8'h00);
      exp_cpu_rd(32'h20);
      to_neg();
      chk("steal_blocked_stall", cpu_stall, 0);
      to_pos();
    end
    exp_kb(32'h100, 8'h32, 1'b1);
    to_neg();
    chk("steal_stall", cpu_stall, 1);
    to_pos();
    exp_cpu_rd(32'h20);
    to_neg();
    chk("steal_resume_stall", cpu_stall, 0);
    chk("steal_ptr", kb_wr_ptr, 1);
    to_pos();

    // Ring pointer wrap: 17 codes with CPU idle
    do_reset();
    for (int i = 0; i < 17; i++) begin
      c = 8'(i);
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, c);
      if (i > 0) begin
        a = 32'h100 + 32'(((i - 1) % 16) * 4);
        exp_kb(a, 8'(i - 1), 1'b0);
      end
      to_neg();
      to_pos();
    end
    idle();
    exp_kb(32'h100, 8'd16, 1'b0);
    to_neg();
    chk("wrap_ptr_during", kb_wr_ptr, 0);
    to_pos();
    to_neg();
    chk("wrap_ptr_after", kb_wr_ptr, 1);
    to_pos();

    // Overflow with a busy CPU
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 8'hA0 + 8'(i));
      exp_cpu_rd(32'h40);
      to_neg();
      chk("ovf_ready_before_full", kb_ready, 1);
      to_pos();
    end
    set_in(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 8'hA4);
    exp_kb(32'h100, 8'hA0, 1'b1);
    to_neg();
    chk("ovf_ready_full", kb_ready, 0);
    chk("ovf_steal", cpu_stall, 1);
    chk("ovf_flag_not_yet", kb_overflow, 0);
    to_pos();
    set_in(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 8'h00);
    exp_cpu_rd(32'h40);
    to_neg();
    chk("ovf_flag_set", kb_overflow, 1);
    chk("ovf_ready_after_pop", kb_ready, 1);
    to_pos();
    for (int i = 0; i < 3; i++) begin
      idle();
      exp_kb(32'h104 + 32'(i * 4), 8'hA1 + 8'(i), 1'b0);
      to_neg();
      to_pos();
    end
    to_neg();
    chk("ovf_flag_sticky", kb_overflow, 1);
    chk("ovf_ptr", kb_wr_ptr, 4);
    to_pos();
    do_reset();
    to_neg();
    chk("ovf_flag_cleared", kb_overflow, 0);
    to_pos();

    // Reset during a steal
    set_in(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 8'h55);
    exp_cpu_rd(32'h50);
    to_neg();
    to_pos();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 8'h00);
      exp_cpu_rd(32'h50);
      to_neg();
      to_pos();
    end
    exp_kb(32'h100, 8'h55, 1'b1);
    to_neg();
    chk("midrst_stall_before", cpu_stall, 1);
    #1 rst = 1'b1;
    to_pos();
    rst = 1'b0;
    idle();
    to_neg();
    chk("midrst_stall_after", cpu_stall, 0);
    chk("midrst_ptr", kb_wr_ptr, 0);
    chk("midrst_fifo_empty", mem_cs, 0);
    to_pos();
    to_neg();
    chk("midrst_no_write", mem_cs, 0);
    to_pos();

    chk("leftover_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU load/store port and the PS/2 keyboard scan-code stream.
- Keyboard codes are buffered in a small FIFO and written into a ring buffer in data memory, during idle CPU slots or by briefly stalling the CPU.
- Sits between the CPU data-memory control signals (cs/r/w/addr/wdata) and the Ram block.

Parameters:
- KB_FIFO_DEPTH, 4: scan-code FIFO entries; power of two.
- KB_BUF_BASE, 32'h0000_0100: byte address of word 0 of the ring buffer.
- KB_BUF_WORDS, 16: ring-buffer length in words; power of two.
- MAX_WAIT, 3: consecutive blocked cycles before the CPU is stalled for a steal; must be ≥1.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  synchronous active-high reset.
- cpu_cs  in  1  CPU data access this cycle.
- cpu_r  in  1  CPU read.
- cpu_w  in  1  CPU write.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU store data.
- cpu_rdata  out  32  load data to CPU.
- cpu_stall  out  1  CPU must hold PC and suppress register-file write this cycle.
- kb_valid  in  1  scan code present, already synchronised to clk.
- kb_code  in  8  scan code.
- kb_ready  out  1  FIFO can accept a code.
- mem_cs  out  1  RAM chip select.
- mem_r  out  1  RAM read.
- mem_w  out  1  RAM write.
- mem_addr  out  32  RAM byte address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM combinational read data.
- kb_wr_ptr  out  log2(KB_BUF_WORDS)  next ring-buffer word index.
- kb_overflow  out  1  sticky: a code was dropped.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on rst.
- All state clears on a clock edge with rst=1:
  - FIFO empty.
  - wait_cnt=0, steal_q=0.
  - kb_wr_ptr=0, kb_overflow=0.
- Outputs during reset and after reset:
  - kb_ready=1.
  - cpu_stall=0.
  - mem_* pass through the CPU port.
- A reset mid-steal abandons the steal. Codes still in the FIFO are discarded.
- FIFO push: on kb_valid && kb_ready.
  - kb_ready = !full. It is computed before any same-cycle pop, so a full FIFO rejects even when it pops that cycle.
- Overflow: kb_valid && !kb_ready sets kb_overflow. The code is lost. kb_overflow stays set until rst.
- Grant rules, evaluated combinationally each cycle, first match wins:
  1. steal_q=1 → KB grant. cpu_stall=1.
  2. FIFO non-empty and cpu_cs=0 → KB grant using the idle slot. cpu_stall=0.
  3. Otherwise → CPU grant. cpu_stall=0.
- CPU grant:
  - mem_cs/r/w/addr/wdata = the cpu_* inputs.
  - No pop.
- KB grant:
  - mem_cs=1, mem_w=1, mem_r=0.
  - mem_addr = KB_BUF_BASE + {kb_wr_ptr, 2'b00}.
  - mem_wdata = {24'h0, FIFO head}.
  - FIFO pops at the clock edge.
  - kb_wr_ptr increments modulo KB_BUF_WORDS and wraps silently; the ring buffer has no read-side tracking.
- cpu_rdata = mem_rdata at all times. The CPU ignores it while stalled.
- Wait counter:
  - Increments on a cycle with CPU grant while the FIFO is non-empty.
  - Clears on any KB grant or when the FIFO is empty.
- steal_q next-state:
  - Set to 1 when the counter's next value reaches MAX_WAIT, or when the FIFO is full and kb_valid=1.
  - Otherwise 0.
  - It is therefore a one-cycle pulse; each steal drains exactly one entry.
- Latency:
  - From push to RAM write: at least 1 cycle (next idle slot).
  - Under saturated CPU traffic: at most MAX_WAIT+1 cycles for the head entry.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, order preserved.
- A steal issued while the FIFO is already empty cannot occur: steal_q is only set when the FIFO is non-empty and no pop is pending.
- States, two: GRANT_CPU (steal_q=0) and GRANT_KB_STEAL (steal_q=1).
  - GRANT_KB_STEAL always returns to GRANT_CPU after one cycle.

Decomposition:
- Shared package holds:
  - KB_BUF_BASE_DEFAULT.
  - Grant encoding GNT_CPU=1'b0 / GNT_KB=1'b1.
  - Function to compute log2 widths.
- One sub-module, kb_fifo: a synchronous FIFO with push/pop/full/empty/head, DEPTH parameter, sync reset.
- Arbitration, the counter and the pointer stay in dmem_port_arbiter.

Test Plan:
- Reset pass-through: assert rst for 2 cycles, then CPU lw addr 0x10 → mem_cs=1, mem_r=1, mem_addr=0x10, cpu_stall=0, kb_ready=1, kb_wr_ptr=0.
- Idle-slot write: cpu_cs=0, push code 0x1C → next cycle mem_w=1, mem_addr=0x100, mem_wdata=0x0000001C, kb_wr_ptr becomes 1, no stall.
- Forced steal: cpu_cs=1 every cycle, push 0x32 → 3 blocked cycles, then cpu_stall=1 for exactly 1 cycle with mem_addr=0x100, then CPU pass-through resumes.
- Pointer wrap: issue 17 pushes with the CPU idle → the 17th write lands at mem_addr=0x100, kb_wr_ptr=1.
- Overflow: cpu_cs=1, push 5 codes back-to-back → kb_ready drops after 4, 5th is dropped, kb_overflow=1, a steal occurs on the full-and-valid cycle, and kb_overflow stays 1 until rst.
- Mid-steal reset: rst asserted in the cycle cpu_stall=1 → next cycle cpu_stall=0, FIFO empty, kb_wr_ptr=0.
